sample_fetch_scheduler: RTL and testbench
=========================================

// Module: sample_fetch_scheduler
// PURPOSE
//  Sequences audio playback from a 22 kHz sample-rate square wave that has
//  already been synchronized into the outclk domain. On each rising edge of
//  that tick it either fetches a 32-bit word from flash over a req/ack
//  handshake, or emits the second 16-bit half of the word already held.
//  Handles forward/reverse play, pause, restart, address wrap-around and
//  counting of dropped ticks. Sits between the synchronizer and the flash
//  reader / audio output.
// PARAMETERS
//  ADDR_W    23          width of the flash word address
//  ADDR_MAX  23'h7FFFF   last word address; playback wraps at this address
//  OVR_W     8           width of the saturating overrun counter
// PORTS
//  outclk       in   1       system clock; all logic is on its rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  sync_tick    in   1       synchronized sample-rate square wave
//  play         in   1       1 = run, 0 = pause (ticks are ignored)
//  dir          in   1       0 = forward, 1 = reverse
//  restart      in   1       one-cycle pulse: return to the start address
//  mem_req      out  1       flash read request; held until mem_ack
//  mem_addr     out  ADDR_W  flash word address; stable while mem_req=1
//  mem_ack      in   1       one-cycle acknowledge; mem_data valid that cycle
//  mem_data     in   32      flash read data
//  sample_out   out  16      current audio sample
//  sample_valid out  1       one-cycle pulse when sample_out updates
//  overrun_cnt  out  OVR_W   dropped-tick count, saturating
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - state=IDLE, half_sel=0, tick_d=1 (no false edge after reset)
//   - mem_req=0, mem_addr=0, sample_out=0, sample_valid=0, overrun_cnt=0
//   - restart_pend=0
//  Tick event: tick_evt = sync_tick & ~tick_d; tick_d is sync_tick
//   registered every cycle.
//  FSM states: IDLE, FETCH, EMIT.
//  IDLE, tick_evt & play & half_sel=0:
//   - go to FETCH; mem_req=1 from the next cycle.
//   - latch word_dir=dir.
//  IDLE, tick_evt & play & half_sel=1:
//   - sample_out = second half of word_q; sample_valid=1 next cycle.
//   - half_sel=0 and advance mem_addr on the same edge.
//  FETCH: mem_req stays 1 and mem_addr stays fixed until mem_ack=1. On ack:
//   - word_q = mem_data; mem_req=0 next cycle; go to EMIT.
//  EMIT (one cycle):
//   - sample_out = first half; sample_valid=1.
//   - half_sel=1; return to IDLE.
//  Half order:
//   - word_dir=0: [15:0] first, then [31:16].
//   - word_dir=1: [31:16] first, then [15:0].
//  Latency:
//   - sample_valid is high in the cycle after the mem_ack cycle.
//   - Second half: sample_valid is high one cycle after tick_evt.
//  Address advance uses the current dir:
//   - forward: ADDR_MAX wraps to 0.
//   - reverse: 0 wraps to ADDR_MAX.
//  tick_evt while state != IDLE: tick is dropped; overrun_cnt+1, saturating
//   at all ones.
//  tick_evt with play=0: ignored, not counted.
//  play falling during FETCH: fetch and EMIT complete normally.
//  restart in IDLE, applied next edge:
//   - mem_addr = dir ? ADDR_MAX : 0; half_sel=0.
//   - restart wins over a simultaneous tick; the tick is not counted.
//  restart in FETCH/EMIT:
//   - set restart_pend; the handshake is never aborted.
//   - If pending when mem_ack arrives: discard data, no sample_valid, go to
//     IDLE, apply the restart.
//  dir change: only affects the next address step or fetch, never the half
//   order of the word already held.
//  rst_n low mid-FETCH: mem_req drops immediately (asynchronously).
// TESTING
//  1. Reset, play=1, dir=0, tick edge, flash acks after 3 cycles with
//     mem_data=32'hBEEF_1234 -> mem_addr=0, sample_out=16'h1234 in the cycle
//     after ack; next tick -> 16'hBEEF, mem_addr=1.
//  2. dir=1, restart pulse -> mem_addr=ADDR_MAX. Fetch 32'hAAAA_5555
//     -> 16'hAAAA, then 16'h5555; mem_addr becomes ADDR_MAX-1.
//  3. Forward at mem_addr=ADDR_MAX, two ticks -> mem_addr wraps to 0.
//     Reverse at 0 -> ADDR_MAX.
//  4. Hold mem_ack low for 300 ticks -> overrun_cnt saturates at 8'hFF;
//     mem_req never drops before ack.
//  5. restart pulse mid-FETCH, then ack -> no sample_valid; mem_addr=0 and
//     half_sel=0 afterwards.
//  6. play=0 for 5 ticks -> no mem_req, no sample_valid, overrun_cnt
//     unchanged. rst_n low during FETCH -> all outputs return to reset
//     values at once.

Source files
------------

// File: rtl/sample_fetch_scheduler.sv
// Sample-rate driven flash fetch sequencer: one 32-bit flash word per two ticks,
// emitting its 16-bit halves in play-direction order, with restart, wrap and overrun count.
module sample_fetch_scheduler #(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 23'h7FFFF,
    parameter int                OVR_W    = 8
) (
    input  logic              outclk,
    input  logic              rst_n,
    input  logic              sync_tick,
    input  logic              play,
    input  logic              dir,
    input  logic              restart,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic [OVR_W-1:0]  overrun_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_tick_d;
    logic              r_half_sel;
    logic              r_word_dir;
    logic              r_restart_pend;
    logic [31:0]       r_word_q;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_sample;
    logic              r_sample_valid;
    logic [OVR_W-1:0]  r_overrun;

    logic              w_tick_evt;
    logic              w_run_tick;
    logic              w_restart_any;
    logic [ADDR_W-1:0] w_restart_addr;
    logic [ADDR_W-1:0] w_addr_step;
    logic [15:0]       w_second_half;
    logic [15:0]       w_ack_first_half;

    assign w_tick_evt     = sync_tick & ~r_tick_d;
    assign w_run_tick     = w_tick_evt & play;
    assign w_restart_any  = restart | r_restart_pend;
    assign w_restart_addr = dir ? ADDR_MAX : '0;

    // The address step follows the live dir input, not the direction the word was fetched in.
    assign w_addr_step = dir ? ((r_addr == '0) ? ADDR_MAX : r_addr - 1'b1)
                             : ((r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1);

    assign w_second_half    = r_word_dir ? r_word_q[15:0] : r_word_q[31:16];
    assign w_ack_first_half = r_word_dir ? mem_data[31:16] : mem_data[15:0];

    always_ff @(posedge outclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_restart_any && w_run_tick && !r_half_sel) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    w_state_next = w_restart_any ? S_IDLE : S_EMIT;
                end
            end
            S_EMIT:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req      = (r_state == S_FETCH);
        mem_addr     = r_addr;
        sample_out   = r_sample;
        sample_valid = r_sample_valid;
        overrun_cnt  = r_overrun;
    end

    always_ff @(posedge outclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d       <= 1'b1;
            r_half_sel     <= 1'b0;
            r_word_dir     <= 1'b0;
            r_restart_pend <= 1'b0;
            r_word_q       <= '0;
            r_addr         <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= '0;
        end else begin
            r_tick_d       <= sync_tick;
            r_sample_valid <= 1'b0;

            if (r_state != S_IDLE && w_run_tick && r_overrun != {OVR_W{1'b1}}) begin
                r_overrun <= r_overrun + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_restart_any) begin
                        r_addr         <= w_restart_addr;
                        r_half_sel     <= 1'b0;
                        r_restart_pend <= 1'b0;
                    end else if (w_run_tick) begin
                        if (!r_half_sel) begin
                            r_word_dir <= dir;
                        end else begin
                            r_sample       <= w_second_half;
                            r_sample_valid <= 1'b1;
                            r_half_sel     <= 1'b0;
                            r_addr         <= w_addr_step;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        if (w_restart_any) begin
                            r_addr         <= w_restart_addr;
                            r_half_sel     <= 1'b0;
                            r_restart_pend <= 1'b0;
                        end else begin
                            // First half goes out on the ack edge so it is valid during EMIT.
                            r_word_q       <= mem_data;
                            r_sample       <= w_ack_first_half;
                            r_sample_valid <= 1'b1;
                        end
                    end else if (restart) begin
                        r_restart_pend <= 1'b1;
                    end
                end
                S_EMIT: begin
                    r_half_sel <= 1'b1;
                    if (restart) begin
                        r_restart_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_fetch_scheduler.sv
// Directed bench for sample_fetch_scheduler: fetch/emit order, wrap, overrun,
// restart during fetch, pause and asynchronous reset.
module tb_sample_fetch_scheduler;

    localparam logic [22:0] AMAX = 23'h7FFFF;

    logic        outclk;
    logic        rst_n;
    logic        sync_tick;
    logic        play;
    logic        dir;
    logic        restart;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [7:0]  overrun_cnt;

    int checks   = 0;
    int failures = 0;
    logic req_held;
    logic quiet_bad;

    sample_fetch_scheduler dut (
        .outclk       (outclk),
        .rst_n        (rst_n),
        .sync_tick    (sync_tick),
        .play         (play),
        .dir          (dir),
        .restart      (restart),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .overrun_cnt  (overrun_cnt)
    );

    initial outclk = 1'b0;
    always #5 outclk = ~outclk;

    task automatic step();
        @(posedge outclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("comparison %s did not match", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; sync_tick = 1'b1; play = 1'b0; dir = 1'b0;
        restart = 1'b0; mem_ack = 1'b0; mem_data = '0;
        repeat (3) step();
        chk("rst_req",    mem_req, 0);
        chk("rst_addr",   mem_addr, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_valid",  sample_valid, 0);
        chk("rst_ovr",    overrun_cnt, 0);

        // sync_tick already high at release must not look like an edge
        play = 1'b1; rst_n = 1'b1;
        repeat (3) step();
        chk("no_false_edge", mem_req, 0);
        sync_tick = 1'b0; step();

        // 1: forward fetch, ack after 3 cycles
        sync_tick = 1'b1; step();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 0);
        sync_tick = 1'b0; step(); step();
        chk("t1_req_hold", mem_req, 1);
        mem_ack = 1'b1; mem_data = 32'hBEEF_1234; step(); mem_ack = 1'b0;
        chk("t1_valid", sample_valid, 1);
        chk("t1_first", sample_out, 16'h1234);
        chk("t1_req_drop", mem_req, 0);
        step();
        chk("t1_pulse", sample_valid, 0);
        sync_tick = 1'b1; step();
        chk("t1_second", sample_out, 16'hBEEF);
        chk("t1_valid2", sample_valid, 1);
        chk("t1_addr_adv", mem_addr, 1);
        sync_tick = 1'b0; step();

        // 2: reverse restart and reverse half order
        dir = 1'b1; restart = 1'b1; step(); restart = 1'b0;
        chk("t2_restart_addr", mem_addr, AMAX);
        sync_tick = 1'b1; step();
        chk("t2_fetch_addr", mem_addr, AMAX);
        sync_tick = 1'b0; mem_ack = 1'b1; mem_data = 32'hAAAA_5555; step(); mem_ack = 1'b0;
        chk("t2_first", sample_out, 16'hAAAA);
        step();
        sync_tick = 1'b1; step();
        chk("t2_second", sample_out, 16'h5555);
        chk("t2_addr", mem_addr, AMAX - 23'd1);
        sync_tick = 1'b0; step();

        // 3: forward wrap ADDR_MAX -> 0, reverse wrap 0 -> ADDR_MAX
        restart = 1'b1; step(); restart = 1'b0; dir = 1'b0;
        chk("t3_start", mem_addr, AMAX);
        sync_tick = 1'b1; step(); sync_tick = 1'b0; step();
        mem_ack = 1'b1; mem_data = 32'h1111_2222; step(); mem_ack = 1'b0;
        chk("t3_fwd_first", sample_out, 16'h2222);
        step();
        sync_tick = 1'b1; step();
        chk("t3_fwd_second", sample_out, 16'h1111);
        chk("t3_fwd_wrap", mem_addr, 0);
        sync_tick = 1'b0; step();
        dir = 1'b1;
        sync_tick = 1'b1; step(); sync_tick = 1'b0;
        mem_ack = 1'b1; mem_data = 32'h3333_4444; step(); mem_ack = 1'b0;
        chk("t3_rev_first", sample_out, 16'h3333);
        step();
        sync_tick = 1'b1; step();
        chk("t3_rev_second", sample_out, 16'h4444);
        chk("t3_rev_wrap", mem_addr, AMAX);
        sync_tick = 1'b0; step();

        // 4: 300 dropped ticks while the flash stalls
        sync_tick = 1'b1; step(); sync_tick = 1'b0; step();
        req_held = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sync_tick = 1'b1; step();
            if (mem_req !== 1'b1) req_held = 1'b0;
            sync_tick = 1'b0; step();
            if (mem_req !== 1'b1) req_held = 1'b0;
            if (i == 9) chk("t4_ovr10", overrun_cnt, 10);
        end
        chk("t4_ovr_sat", overrun_cnt, 8'hFF);
        chk("t4_req_held", req_held, 1);
        chk("t4_addr_stable", mem_addr, AMAX);
        mem_ack = 1'b1; mem_data = 32'h5678_9ABC; step(); mem_ack = 1'b0;
        chk("t4_first", sample_out, 16'h5678);
        step();
        sync_tick = 1'b1; step();
        chk("t4_second", sample_out, 16'h9ABC);
        chk("t4_addr", mem_addr, AMAX - 23'd1);
        sync_tick = 1'b0; step();

        // 5: restart during FETCH discards the word
        dir = 1'b0;
        sync_tick = 1'b1; step();
        chk("t5_fetch_addr", mem_addr, AMAX - 23'd1);
        sync_tick = 1'b0; step();
        restart = 1'b1; step(); restart = 1'b0;
        chk("t5_req_kept", mem_req, 1);
        step();
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; step(); mem_ack = 1'b0;
        chk("t5_no_valid", sample_valid, 0);
        chk("t5_req_drop", mem_req, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_sample_kept", sample_out, 16'h9ABC);
        step();
        chk("t5_no_valid2", sample_valid, 0);
        sync_tick = 1'b1; step();
        chk("t5_half_clear", mem_req, 1);
        chk("t5_valid_tick", sample_valid, 0);
        sync_tick = 1'b0; mem_ack = 1'b1; mem_data = 32'h0000_CAFE; step(); mem_ack = 1'b0;
        chk("t5_first", sample_out, 16'hCAFE);
        step();

        // 6: pause, then asynchronous reset mid-FETCH
        play = 1'b0; quiet_bad = 1'b0;
        repeat (5) begin
            sync_tick = 1'b1; step();
            if (mem_req || sample_valid) quiet_bad = 1'b1;
            sync_tick = 1'b0; step();
            if (mem_req || sample_valid) quiet_bad = 1'b1;
        end
        chk("t6_quiet", quiet_bad, 0);
        chk("t6_ovr_same", overrun_cnt, 8'hFF);
        play = 1'b1;
        sync_tick = 1'b1; step();
        chk("t6_second_valid", sample_valid, 1);
        chk("t6_addr", mem_addr, 1);
        sync_tick = 1'b0; step();
        sync_tick = 1'b1; step();
        chk("t6_fetch", mem_req, 1);
        sync_tick = 1'b0; step();
        rst_n = 1'b0; #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_ovr", overrun_cnt, 0);
        chk("t6_rst_valid", sample_valid, 0);
        chk("t6_rst_sample", sample_out, 0);
        step(); rst_n = 1'b1; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
